multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RV32I datapath: sequences fetch, decode, execute,
// memory access and writeback, with a per-access memory timeout and a sticky fault.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT     = 16,
  parameter int HALT_ON_ILLEGAL = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] inst,
  input  logic        BrEq,
  input  logic        BrLT,
  input  logic        MemReady,
  output logic        PCSel,
  output logic [2:0]  ImmSel,
  output logic        RegWEn,
  output logic        BrUn,
  output logic        BSel,
  output logic        ASel,
  output logic [3:0]  ALUSel,
  output logic        MemRW,
  output logic [1:0]  WBSel,
  output logic        MemReq,
  output logic        IorD,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        Fault,
  output logic        InstRet
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
  } state_e;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_REG    = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_SLL   = 4'b0010;
  localparam logic [3:0] ALU_SLT   = 4'b0011;
  localparam logic [3:0] ALU_SLTU  = 4'b0100;
  localparam logic [3:0] ALU_XOR   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_OR    = 4'b1000;
  localparam logic [3:0] ALU_AND   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1111;

  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_IU    = 3'b001;
  localparam logic [2:0] IMM_SHAMT = 3'b010;
  localparam logic [2:0] IMM_S     = 3'b011;
  localparam logic [2:0] IMM_B     = 3'b100;
  localparam logic [2:0] IMM_U     = 3'b101;
  localparam logic [2:0] IMM_J     = 3'b110;
  localparam logic [2:0] IMM_JALR  = 3'b111;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [8:0] wait_inc;
  logic       timeout;

  logic [4:0] opc;
  logic [2:0] f3;
  logic       is_load, is_store, is_branch, is_jal, is_jalr;
  logic       is_opimm, is_opreg, is_lui, is_auipc, legal, br_taken;
  logic       unused_inst;

  // Only opcode, funct3 and the funct7 alternate bit steer control.
  assign opc         = inst[6:2];
  assign f3          = inst[14:12];
  assign unused_inst = ^{inst[31], inst[29:15], inst[11:7], inst[1:0]};

  assign is_load   = (opc == OP_LOAD);
  assign is_store  = (opc == OP_STORE);
  assign is_branch = (opc == OP_BRANCH);
  assign is_jal    = (opc == OP_JAL);
  assign is_jalr   = (opc == OP_JALR);
  assign is_opimm  = (opc == OP_IMM);
  assign is_opreg  = (opc == OP_REG);
  assign is_lui    = (opc == OP_LUI);
  assign is_auipc  = (opc == OP_AUIPC);
  assign legal     = is_load | is_store | is_jal | is_jalr | is_opimm | is_opreg |
                     is_lui | is_auipc | (is_branch & (f3[2:1] != 2'b01));

  function automatic logic [3:0] alu_op(input logic [2:0] fn3, input logic alt,
                                        input logic imm_form);
    case (fn3)
      3'b000:  alu_op = (alt && !imm_form) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  always_comb begin
    case (f3)
      3'b000:         br_taken = BrEq;
      3'b001:         br_taken = !BrEq;
      3'b100, 3'b110: br_taken = BrLT;
      3'b101, 3'b111: br_taken = !BrLT;
      default:        br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wait_d   = '0;
    wait_inc = {1'b0, wait_q} + 9'd1;
    timeout  = (wait_inc == TIMEOUT_LIM);
    PCSel    = 1'b0;
    ImmSel   = IMM_I;
    RegWEn   = 1'b0;
    BrUn     = 1'b0;
    BSel     = 1'b0;
    ASel     = 1'b0;
    ALUSel   = ALU_ADD;
    MemRW    = 1'b0;
    WBSel    = WB_MEM;
    MemReq   = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    Fault    = 1'b0;
    InstRet  = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        MemReq = 1'b1;
        if (MemReady) begin
          IRWrite = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_inc[7:0];
        end
      end

      S_DECODE: state_d = (!legal && HALT_ON_ILLEGAL != 0) ? S_FAULT : S_EXEC;

      S_EXEC: begin
        state_d = S_FETCH;
        if (!legal) begin
          // Illegal opcode retires as a NOP when not halting.
          PCWrite = 1'b1;
          InstRet = 1'b1;
        end else if (is_load || is_store) begin
          BSel    = 1'b1;
          ImmSel  = is_store ? IMM_S : IMM_I;
          state_d = S_MEM;
        end else if (is_branch) begin
          PCSel   = br_taken;
          BrUn    = f3[1];
          ASel    = 1'b1;
          BSel    = 1'b1;
          ImmSel  = IMM_B;
          PCWrite = 1'b1;
          InstRet = 1'b1;
        end else if (is_jal || is_jalr) begin
          PCSel   = 1'b1;
          RegWEn  = 1'b1;
          WBSel   = WB_PC4;
          BSel    = 1'b1;
          ASel    = is_jal;
          ImmSel  = is_jal ? IMM_J : IMM_JALR;
          PCWrite = 1'b1;
          InstRet = 1'b1;
        end else begin
          RegWEn  = 1'b1;
          WBSel   = WB_ALU;
          PCWrite = 1'b1;
          InstRet = 1'b1;
          if (is_lui) begin
            ALUSel = ALU_PASSB;
            BSel   = 1'b1;
            ImmSel = IMM_U;
          end else if (is_auipc) begin
            ASel   = 1'b1;
            BSel   = 1'b1;
            ImmSel = IMM_U;
          end else begin
            ALUSel = alu_op(f3, inst[30], is_opimm);
            if (is_opimm) begin
              BSel = 1'b1;
              if (f3[1:0] == 2'b01)  ImmSel = IMM_SHAMT;
              else if (f3 == 3'b011) ImmSel = IMM_IU;
              else                   ImmSel = IMM_I;
            end
          end
        end
      end

      S_MEM: begin
        // Address path held identical to EXEC for the whole access.
        MemReq = 1'b1;
        IorD   = 1'b1;
        MemRW  = is_store;
        BSel   = 1'b1;
        ImmSel = is_store ? IMM_S : IMM_I;
        if (MemReady) begin
          if (is_store) begin
            PCWrite = 1'b1;
            InstRet = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_inc[7:0];
        end
      end

      S_WB: begin
        RegWEn  = 1'b1;
        WBSel   = WB_MEM;
        PCWrite = 1'b1;
        InstRet = 1'b1;
        state_d = S_FETCH;
      end

      S_FAULT: Fault = 1'b1;

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: one halting instance with a short memory timeout
// and one non-halting instance, driven in lockstep from shared inputs.
module tb_multicycle_ctrl;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] inst = '0;
  logic        BrEq = 1'b0, BrLT = 1'b0, MemReady = 1'b0;

  logic PCSel, RegWEn, BrUn, BSel, ASel, MemRW, MemReq, IorD, IRWrite, PCWrite, Fault, InstRet;
  logic [2:0] ImmSel;
  logic [3:0] ALUSel;
  logic [1:0] WBSel;
  logic PCSel_n, RegWEn_n, BrUn_n, BSel_n, ASel_n, MemRW_n, MemReq_n, IorD_n;
  logic IRWrite_n, PCWrite_n, Fault_n, InstRet_n;
  logic [2:0] ImmSel_n;
  logic [3:0] ALUSel_n;
  logic [1:0] WBSel_n;

  logic [20:0] outs, outs_n;
  int checks = 0;
  int errors = 0;

  localparam logic [20:0] P_PCSEL  = 21'h100000;
  localparam logic [20:0] P_REGWEN = 21'h010000;
  localparam logic [20:0] P_BRUN   = 21'h008000;
  localparam logic [20:0] P_BSEL   = 21'h004000;
  localparam logic [20:0] P_ASEL   = 21'h002000;
  localparam logic [20:0] P_MEMRW  = 21'h000100;
  localparam logic [20:0] P_MEMREQ = 21'h000020;
  localparam logic [20:0] P_IORD   = 21'h000010;
  localparam logic [20:0] P_IRW    = 21'h000008;
  localparam logic [20:0] P_PCW    = 21'h000004;
  localparam logic [20:0] P_FAULT  = 21'h000002;
  localparam logic [20:0] P_RET    = 21'h000001;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_AND   = 32'h0020F1B3;
  localparam logic [31:0] I_SRAI  = 32'h4020D193;
  localparam logic [31:0] I_SLTIU = 32'h0050B193;
  localparam logic [31:0] I_LUI   = 32'h123451B7;
  localparam logic [31:0] I_AUIPC = 32'h00001197;
  localparam logic [31:0] I_LW    = 32'h0080A283;
  localparam logic [31:0] I_SW    = 32'h0020A223;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_BNE   = 32'h00209463;
  localparam logic [31:0] I_BLT   = 32'h0020C463;
  localparam logic [31:0] I_BLTU  = 32'h0020E463;
  localparam logic [31:0] I_BGEU  = 32'h0020F463;
  localparam logic [31:0] I_BBAD  = 32'h0020A463;
  localparam logic [31:0] I_JAL   = 32'h010000EF;
  localparam logic [31:0] I_JALR  = 32'h000100E7;
  localparam logic [31:0] I_ILL   = 32'h0000007F;

  function automatic logic [20:0] imm(input logic [2:0] v);
    return 21'(v) << 17;
  endfunction
  function automatic logic [20:0] alu(input logic [3:0] v);
    return 21'(v) << 9;
  endfunction
  function automatic logic [20:0] wb(input logic [1:0] v);
    return 21'(v) << 6;
  endfunction

  multicycle_ctrl #(.MEM_TIMEOUT(4), .HALT_ON_ILLEGAL(1)) dut (
    .Clock(Clock), .Reset(Reset), .inst(inst), .BrEq(BrEq), .BrLT(BrLT), .MemReady(MemReady),
    .PCSel(PCSel), .ImmSel(ImmSel), .RegWEn(RegWEn), .BrUn(BrUn), .BSel(BSel), .ASel(ASel),
    .ALUSel(ALUSel), .MemRW(MemRW), .WBSel(WBSel), .MemReq(MemReq), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .Fault(Fault), .InstRet(InstRet)
  );

  multicycle_ctrl #(.MEM_TIMEOUT(16), .HALT_ON_ILLEGAL(0)) dut_n (
    .Clock(Clock), .Reset(Reset), .inst(inst), .BrEq(BrEq), .BrLT(BrLT), .MemReady(MemReady),
    .PCSel(PCSel_n), .ImmSel(ImmSel_n), .RegWEn(RegWEn_n), .BrUn(BrUn_n), .BSel(BSel_n),
    .ASel(ASel_n), .ALUSel(ALUSel_n), .MemRW(MemRW_n), .WBSel(WBSel_n), .MemReq(MemReq_n),
    .IorD(IorD_n), .IRWrite(IRWrite_n), .PCWrite(PCWrite_n), .Fault(Fault_n), .InstRet(InstRet_n)
  );

  assign outs   = {PCSel, ImmSel, RegWEn, BrUn, BSel, ASel, ALUSel, MemRW, WBSel,
                   MemReq, IorD, IRWrite, PCWrite, Fault, InstRet};
  assign outs_n = {PCSel_n, ImmSel_n, RegWEn_n, BrUn_n, BSel_n, ASel_n, ALUSel_n, MemRW_n,
                   WBSel_n, MemReq_n, IorD_n, IRWrite_n, PCWrite_n, Fault_n, InstRet_n};

  always #5 Clock = ~Clock;

  task automatic next_cycle(input logic mr);
    @(posedge Clock);
    #1;
    MemReady = mr;
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    MemReady = 1'b0;
    BrEq = 1'b0;
    BrLT = 1'b0;
    next_cycle(1'b0);
    next_cycle(1'b0);
    Reset = 1'b0;
  endtask

  task automatic go_to_exec(input logic [31:0] ins);
    inst = ins;
    next_cycle(1'b1);
    next_cycle(1'b1);
    next_cycle(1'b0);
  endtask

  task automatic test_reset();
    logic [20:0] mem_st;
    mem_st = P_MEMREQ | P_IORD | P_MEMRW | P_BSEL | imm(3'b011);
    Reset = 1'b1;
    next_cycle(1'b0);
    next_cycle(1'b0);
    checks++;
    if (outs !== 21'h0 || outs_n !== 21'h0) begin
      errors++;
      $display("FAIL reset_idle: got %h/%h expected 000000", outs, outs_n);
    end
    Reset = 1'b0;
    go_to_exec(I_SW);
    for (int k = 0; k < 2; k++) begin
      next_cycle(1'b0);
      checks++;
      if (outs !== mem_st) begin
        errors++;
        $display("FAIL store_mem_hold[%0d]: got %h expected %h", k, outs, mem_st);
      end
    end
    Reset = 1'b1;
    next_cycle(1'b0);
    checks++;
    if (outs !== 21'h0) begin
      errors++;
      $display("FAIL reset_mid_mem: got %h expected 000000", outs);
    end
    Reset = 1'b0;
    next_cycle(1'b1);
    checks++;
    if (outs !== (P_MEMREQ | P_IRW)) begin
      errors++;
      $display("FAIL fetch_after_reset: got %h expected %h", outs, P_MEMREQ | P_IRW);
    end
  endtask

  task automatic test_add();
    logic [20:0] exp_t [5];
    int rets;
    exp_t[0] = 21'h0;
    exp_t[1] = P_MEMREQ | P_IRW;
    exp_t[2] = 21'h0;
    exp_t[3] = P_REGWEN | wb(2'b01) | P_PCW | P_RET | alu(4'b0000);
    exp_t[4] = P_MEMREQ | P_IRW;
    rets = 0;
    do_reset();
    inst = I_ADD;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_cycle(1'b1);
      rets += int'(InstRet);
      checks++;
      if (outs !== exp_t[i]) begin
        errors++;
        $display("FAIL add_cycle%0d: got %h expected %h", i + 1, outs, exp_t[i]);
      end
    end
    checks++;
    if (rets != 1) begin
      errors++;
      $display("FAIL add_instret_count: got %0d expected 1", rets);
    end
  endtask

  task automatic test_alu();
    logic [31:0] ins_t [6];
    logic [20:0] exp_t [6];
    logic [20:0] base;
    base = P_REGWEN | wb(2'b01) | P_PCW | P_RET;
    ins_t[0] = I_SUB;   exp_t[0] = base | alu(4'b0001);
    ins_t[1] = I_AND;   exp_t[1] = base | alu(4'b1001);
    ins_t[2] = I_SRAI;  exp_t[2] = base | alu(4'b0111) | P_BSEL | imm(3'b010);
    ins_t[3] = I_SLTIU; exp_t[3] = base | alu(4'b0100) | P_BSEL | imm(3'b001);
    ins_t[4] = I_LUI;   exp_t[4] = base | alu(4'b1111) | P_BSEL | imm(3'b101);
    ins_t[5] = I_AUIPC; exp_t[5] = base | P_ASEL | P_BSEL | imm(3'b101);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      go_to_exec(ins_t[i]);
      checks++;
      if (outs !== exp_t[i]) begin
        errors++;
        $display("FAIL alu_exec[%0d]: got %h expected %h", i, outs, exp_t[i]);
      end
    end
  endtask

  task automatic test_load();
    logic [20:0] mem_ld, wb_v;
    int wbs;
    mem_ld = P_MEMREQ | P_IORD | P_BSEL;
    wb_v = P_REGWEN | P_PCW | P_RET;
    wbs = 0;
    do_reset();
    go_to_exec(I_LW);
    checks++;
    if (outs !== P_BSEL) begin
      errors++;
      $display("FAIL lw_exec: got %h expected %h", outs, P_BSEL);
    end
    for (int k = 0; k < 4; k++) begin
      next_cycle(k == 3);
      if (RegWEn && WBSel == 2'b00) wbs++;
      checks++;
      if (outs !== mem_ld) begin
        errors++;
        $display("FAIL lw_mem[%0d]: got %h expected %h", k, outs, mem_ld);
      end
    end
    next_cycle(1'b1);
    if (RegWEn && WBSel == 2'b00) wbs++;
    checks++;
    if (outs !== wb_v) begin
      errors++;
      $display("FAIL lw_wb: got %h expected %h", outs, wb_v);
    end
    next_cycle(1'b1);
    if (RegWEn && WBSel == 2'b00) wbs++;
    checks++;
    if (outs !== (P_MEMREQ | P_IRW) || wbs != 1) begin
      errors++;
      $display("FAIL lw_refetch: got %h wb=%0d expected %h wb=1", outs, wbs, P_MEMREQ | P_IRW);
    end
  endtask

  task automatic test_store();
    logic [20:0] mem_st;
    mem_st = P_MEMREQ | P_IORD | P_MEMRW | P_BSEL | imm(3'b011) | P_PCW | P_RET;
    do_reset();
    go_to_exec(I_SW);
    checks++;
    if (outs !== (P_BSEL | imm(3'b011))) begin
      errors++;
      $display("FAIL sw_exec: got %h expected %h", outs, P_BSEL | imm(3'b011));
    end
    next_cycle(1'b1);
    checks++;
    if (outs !== mem_st) begin
      errors++;
      $display("FAIL sw_mem_done: got %h expected %h", outs, mem_st);
    end
    next_cycle(1'b1);
    checks++;
    if (outs !== (P_MEMREQ | P_IRW)) begin
      errors++;
      $display("FAIL sw_refetch: got %h expected %h", outs, P_MEMREQ | P_IRW);
    end
  endtask

  task automatic test_branch();
    logic [31:0] ins_t [7];
    logic        eq_t [7];
    logic        lt_t [7];
    logic [20:0] exp_t [7];
    logic [20:0] base;
    base = P_PCW | P_RET | P_ASEL | P_BSEL | imm(3'b100);
    ins_t[0] = I_BGEU; eq_t[0] = 0; lt_t[0] = 0; exp_t[0] = base | P_BRUN | P_PCSEL;
    ins_t[1] = I_BGEU; eq_t[1] = 0; lt_t[1] = 1; exp_t[1] = base | P_BRUN;
    ins_t[2] = I_BEQ;  eq_t[2] = 1; lt_t[2] = 0; exp_t[2] = base | P_PCSEL;
    ins_t[3] = I_BEQ;  eq_t[3] = 0; lt_t[3] = 1; exp_t[3] = base;
    ins_t[4] = I_BNE;  eq_t[4] = 1; lt_t[4] = 0; exp_t[4] = base;
    ins_t[5] = I_BLT;  eq_t[5] = 0; lt_t[5] = 1; exp_t[5] = base | P_PCSEL;
    ins_t[6] = I_BLTU; eq_t[6] = 0; lt_t[6] = 1; exp_t[6] = base | P_BRUN | P_PCSEL;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      BrEq = eq_t[i];
      BrLT = lt_t[i];
      go_to_exec(ins_t[i]);
      checks++;
      if (outs !== exp_t[i]) begin
        errors++;
        $display("FAIL branch_exec[%0d]: got %h expected %h", i, outs, exp_t[i]);
      end
    end
  endtask

  task automatic test_jump();
    logic [20:0] base;
    base = P_PCSEL | P_REGWEN | wb(2'b10) | P_PCW | P_RET | P_BSEL;
    do_reset();
    go_to_exec(I_JAL);
    checks++;
    if (outs !== (base | P_ASEL | imm(3'b110))) begin
      errors++;
      $display("FAIL jal_exec: got %h expected %h", outs, base | P_ASEL | imm(3'b110));
    end
    go_to_exec(I_JALR);
    checks++;
    if (outs !== (base | imm(3'b111))) begin
      errors++;
      $display("FAIL jalr_exec: got %h expected %h", outs, base | imm(3'b111));
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      next_cycle(1'b0);
      checks++;
      if (outs !== P_MEMREQ) begin
        errors++;
        $display("FAIL fetch_wait[%0d]: got %h expected %h", k, outs, P_MEMREQ);
      end
    end
    for (int k = 0; k < 4; k++) begin
      next_cycle(k != 0);
      checks++;
      if (outs !== P_FAULT) begin
        errors++;
        $display("FAIL fault_sticky[%0d]: got %h expected %h", k, outs, P_FAULT);
      end
    end
    Reset = 1'b1;
    next_cycle(1'b1);
    checks++;
    if (outs !== 21'h0) begin
      errors++;
      $display("FAIL fault_reset: got %h expected 000000", outs);
    end
    Reset = 1'b0;
    next_cycle(1'b1);
    checks++;
    if (outs !== (P_MEMREQ | P_IRW)) begin
      errors++;
      $display("FAIL fault_refetch: got %h expected %h", outs, P_MEMREQ | P_IRW);
    end
    do_reset();
    go_to_exec(I_LW);
    for (int k = 0; k < 4; k++) next_cycle(1'b0);
    checks++;
    if (outs !== (P_MEMREQ | P_IORD | P_BSEL)) begin
      errors++;
      $display("FAIL mem_wait_last: got %h expected %h", outs, P_MEMREQ | P_IORD | P_BSEL);
    end
    next_cycle(1'b0);
    checks++;
    if (outs !== P_FAULT) begin
      errors++;
      $display("FAIL mem_timeout: got %h expected %h", outs, P_FAULT);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ins_t [2];
    ins_t[0] = I_ILL;
    ins_t[1] = I_BBAD;
    for (int i = 0; i < 2; i++) begin
      do_reset();
      go_to_exec(ins_t[i]);
      checks++;
      if (outs !== P_FAULT || outs_n !== (P_PCW | P_RET)) begin
        errors++;
        $display("FAIL illegal_exec[%0d]: got %h/%h expected %h/%h", i, outs, outs_n,
                 P_FAULT, P_PCW | P_RET);
      end
      next_cycle(1'b1);
      checks++;
      if (outs !== P_FAULT || outs_n !== (P_MEMREQ | P_IRW)) begin
        errors++;
        $display("FAIL illegal_after[%0d]: got %h/%h expected %h/%h", i, outs, outs_n,
                 P_FAULT, P_MEMREQ | P_IRW);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_add();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_jump();
    test_timeout();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
